ct_ifu_ibuf_rd_ctrl: RTL and testbench

Read side of the IFU instruction buffer. Consumes the per-entry half-word ring written by the ibuf entries, assembles up to two 16/32-bit instructions per cycle, and registers them toward IDU. Issues per-entry retire strobes back to the entries. Sits between the ibuf entry array and the IFU→IDU instruction interface.

---
 rtl/ct_ifu_ibuf_rd_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ct_ifu_ibuf_rd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_ifu_ibuf_rd_ctrl.sv
// -----------------------------------------------------------------------------
// ct_ifu_ibuf_rd_ctrl
//
// Read side of the IFU instruction buffer. Looks at the four half-word entries
// starting at rd_ptr, assembles up to two 16/32-bit instructions per cycle and
// registers them toward IDU. Consumed entries get a combinational retire strobe
// in the accept cycle, so they drop valid on the same edge that rd_ptr moves
// past them.
//
// Ports
//   forever_cpuclk      block clock
//   cpurst_b            asynchronous active-low reset
//   ibuf_flush          clears rd_ptr and the output valids; wins over accept
//   entry_vld_v         per-entry valid
//   entry_inst_data_v   per-entry half-word, entry i at [16i+15:16i]
//   entry_32_start_v    entry is the low half of a 32-bit instruction
//   entry_acc_err_v     entry carries a fetch exception
//   entry_pc_v          per-entry pc, entry i at [15i+14:15i]
//   idu_ifu_ib_stall    IDU cannot take the output stage
//   entry_retire_v      per-entry retire strobe (combinational)
//   rd_ptr              current read pointer
//   inst0_* / inst1_*   registered instruction slots toward IDU
//   inst0_expt          slot0 holds an exception (slot1 never does)
// -----------------------------------------------------------------------------
module ct_ifu_ibuf_rd_ctrl #(
  parameter int ENTRY_NUM = 16,
  parameter int PTR_W     = 4
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst_b,
  input  logic                    ibuf_flush,
  input  logic [ENTRY_NUM-1:0]    entry_vld_v,
  input  logic [16*ENTRY_NUM-1:0] entry_inst_data_v,
  input  logic [ENTRY_NUM-1:0]    entry_32_start_v,
  input  logic [ENTRY_NUM-1:0]    entry_acc_err_v,
  input  logic [15*ENTRY_NUM-1:0] entry_pc_v,
  input  logic                    idu_ifu_ib_stall,
  output logic [ENTRY_NUM-1:0]    entry_retire_v,
  output logic [PTR_W-1:0]        rd_ptr,
  output logic                    inst0_vld,
  output logic [31:0]             inst0_data,
  output logic                    inst0_32,
  output logic [14:0]             inst0_pc,
  output logic                    inst0_expt,
  output logic                    inst1_vld,
  output logic [31:0]             inst1_data,
  output logic                    inst1_32,
  output logic [14:0]             inst1_pc
);

  // Two slots of at most two half-words each never look further than 4 entries.
  localparam int WIN = 4;

  logic [PTR_W-1:0] win_idx   [WIN];
  logic             win_vld   [WIN];
  logic [15:0]      win_data  [WIN];
  logic             win_start [WIN];
  logic             win_acc   [WIN];
  logic [14:0]      win_pc    [WIN];

  // Window onto the ring; the PTR_W-bit add wraps modulo ENTRY_NUM.
  always_comb begin
    for (int k = 0; k < WIN; k++) begin
      win_idx[k]   = rd_ptr + PTR_W'(k);
      win_vld[k]   = entry_vld_v[win_idx[k]];
      win_data[k]  = entry_inst_data_v[16*int'(win_idx[k]) +: 16];
      win_start[k] = entry_32_start_v[win_idx[k]];
      win_acc[k]   = entry_acc_err_v[win_idx[k]];
      win_pc[k]    = entry_pc_v[15*int'(win_idx[k]) +: 15];
    end
  end

  // ---------------------------------------------------------------------------
  // Slot candidates
  // ---------------------------------------------------------------------------
  logic        s0_vld;
  logic        s0_32;
  logic [31:0] s0_data;
  logic        s1_vld;
  logic        s1_32;
  logic [31:0] s1_data;
  logic [14:0] s1_pc;
  logic        b_vld;    // first half-word of slot1
  logic [15:0] b_data;
  logic        b_start;
  logic        b_acc;
  logic [14:0] b_pc;
  logic        h_vld;    // half-word after it (slot1 high half)
  logic [15:0] h_data;
  logic [2:0]  consumed;
  logic        accept;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (defaults first or a full if/else); a path that skips one infers a latch.
  always_comb begin
    // An exception entry is always a one-half-word instruction, even when its
    // 32-bit start bit is also set.
    s0_32   = ~win_acc[0] & win_start[0];
    s0_vld  = win_vld[0] & (~s0_32 | win_vld[1]);
    s0_data = s0_32 ? {win_data[1], win_data[0]} : {16'h0000, win_data[0]};

    if (s0_32) begin
      b_vld   = win_vld[2];
      b_data  = win_data[2];
      b_start = win_start[2];
      b_acc   = win_acc[2];
      b_pc    = win_pc[2];
      h_vld   = win_vld[3];
      h_data  = win_data[3];
    end else begin
      b_vld   = win_vld[1];
      b_data  = win_data[1];
      b_start = win_start[1];
      b_acc   = win_acc[1];
      b_pc    = win_pc[1];
      h_vld   = win_vld[2];
      h_data  = win_data[2];
    end

    // Slot1 is never an exception: an exception entry waits to become slot0,
    // and an exception in slot0 issues alone.
    s1_32   = b_start;
    s1_vld  = s0_vld & ~win_acc[0] & b_vld & ~b_acc & (~b_start | h_vld);
    s1_data = b_start ? {h_data, b_data} : {16'h0000, b_data};
    s1_pc   = b_pc;

    consumed = 3'd0;
    if (s0_vld) begin
      consumed = s0_32 ? 3'd2 : 3'd1;
      if (s1_vld) begin
        consumed = consumed + (s1_32 ? 3'd2 : 3'd1);
      end
    end
  end

  // The output stage is free when empty or drained by IDU; flush overrides.
  assign accept = (~inst0_vld | ~idu_ifu_ib_stall) & ~ibuf_flush;

  // ---------------------------------------------------------------------------
  // Retire strobes: one per consumed entry, only in an accept cycle. The window
  // entries are distinct because ENTRY_NUM >= WIN.
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_retire_v = '0;
    for (int k = 0; k < WIN; k++) begin
      if (accept && (k < int'(consumed))) begin
        entry_retire_v[win_idx[k]] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pointer and output stage
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_ptr     <= '0;
      inst0_vld  <= 1'b0;
      inst0_data <= '0;
      inst0_32   <= 1'b0;
      inst0_pc   <= '0;
      inst0_expt <= 1'b0;
      inst1_vld  <= 1'b0;
      inst1_data <= '0;
      inst1_32   <= 1'b0;
      inst1_pc   <= '0;
    end else if (ibuf_flush) begin
      rd_ptr    <= '0;
      inst0_vld <= 1'b0;
      inst1_vld <= 1'b0;
    end else if (accept) begin
      rd_ptr     <= rd_ptr + PTR_W'(consumed);
      inst0_vld  <= s0_vld;
      inst0_data <= s0_data;
      inst0_32   <= s0_32;
      inst0_pc   <= win_pc[0];
      inst0_expt <= win_acc[0];
      inst1_vld  <= s1_vld;
      inst1_data <= s1_data;
      inst1_32   <= s1_32;
      inst1_pc   <= s1_pc;
    end
  end

endmodule

// File: tb/tb_ct_ifu_ibuf_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ct_ifu_ibuf_rd_ctrl
//
// The bench plays the ibuf entry array: it writes a random instruction stream
// (16-bit, 32-bit and exception half-words) into the ring in order and clears
// entries as they are consumed. The reference model sees the pending stream as
// a plain queue of half-words and parses up to two instructions off its front.
// Expected output-stage contents are pushed into a scoreboard queue each cycle;
// a monitor pops and compares them after every clock edge.
// -----------------------------------------------------------------------------
module tb_ct_ifu_ibuf_rd_ctrl;

  localparam int N      = 16;
  localparam int PW     = 4;
  localparam int CYCLES = 700;

  logic              forever_cpuclk = 1'b0;
  logic              cpurst_b;
  logic              ibuf_flush;
  logic [N-1:0]      entry_vld_v;
  logic [16*N-1:0]   entry_inst_data_v;
  logic [N-1:0]      entry_32_start_v;
  logic [N-1:0]      entry_acc_err_v;
  logic [15*N-1:0]   entry_pc_v;
  logic              idu_ifu_ib_stall;
  logic [N-1:0]      entry_retire_v;
  logic [PW-1:0]     rd_ptr;
  logic              inst0_vld, inst0_32, inst0_expt;
  logic [31:0]       inst0_data;
  logic [14:0]       inst0_pc;
  logic              inst1_vld, inst1_32;
  logic [31:0]       inst1_data;
  logic [14:0]       inst1_pc;

  ct_ifu_ibuf_rd_ctrl #(.ENTRY_NUM(N), .PTR_W(PW)) dut (
    .forever_cpuclk    (forever_cpuclk),
    .cpurst_b          (cpurst_b),
    .ibuf_flush        (ibuf_flush),
    .entry_vld_v       (entry_vld_v),
    .entry_inst_data_v (entry_inst_data_v),
    .entry_32_start_v  (entry_32_start_v),
    .entry_acc_err_v   (entry_acc_err_v),
    .entry_pc_v        (entry_pc_v),
    .idu_ifu_ib_stall  (idu_ifu_ib_stall),
    .entry_retire_v    (entry_retire_v),
    .rd_ptr            (rd_ptr),
    .inst0_vld         (inst0_vld),
    .inst0_data        (inst0_data),
    .inst0_32          (inst0_32),
    .inst0_pc          (inst0_pc),
    .inst0_expt        (inst0_expt),
    .inst1_vld         (inst1_vld),
    .inst1_data        (inst1_data),
    .inst1_32          (inst1_32),
    .inst1_pc          (inst1_pc)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  typedef struct {
    logic [15:0] data;
    logic        start;
    logic        acc;
    logic [14:0] pc;
  } hw_t;

  typedef struct {
    logic        vld0, vld1, b32_0, b32_1, expt;
    logic [31:0] d0, d1;
    logic [14:0] pc0, pc1;
    logic [3:0]  ptr;
  } exp_t;

  int checks   = 0;
  int failures = 0;

  // Entry array as seen by the DUT.
  logic        env_vld   [N];
  logic [15:0] env_data  [N];
  logic        env_start [N];
  logic        env_acc   [N];
  logic [14:0] env_pc    [N];

  // Reference model state.
  hw_t   hw_q[$];   // half-words written and not yet consumed, oldest first
  hw_t   gen_q[$];  // upstream stream not yet written into the ring
  exp_t  exp_q[$];  // scoreboard
  exp_t  m_out;
  exp_t  mon_e;
  int    m_ptr;
  int    wr_ptr;
  logic [14:0] pc_ctr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_entries();
    for (int i = 0; i < N; i++) begin
      entry_vld_v[i]               = env_vld[i];
      entry_inst_data_v[16*i +: 16] = env_data[i];
      entry_32_start_v[i]          = env_start[i];
      entry_acc_err_v[i]           = env_acc[i];
      entry_pc_v[15*i +: 15]        = env_pc[i];
    end
  endtask

  task automatic push_hw(input logic [15:0] data, input logic start, input logic acc);
    hw_t h;
    h.data  = data;
    h.start = start;
    h.acc   = acc;
    h.pc    = pc_ctr;
    pc_ctr  = pc_ctr + 15'd1;
    gen_q.push_back(h);
  endtask

  // One random instruction: 10% exception (start bit random), 40% 32-bit, else 16-bit.
  task automatic gen_inst();
    int kind;
    kind = $urandom_range(0, 9);
    if (kind == 0) begin
      push_hw(16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end else if (kind < 5) begin
      push_hw(16'($urandom), 1'b1, 1'b0);
      push_hw(16'($urandom), 1'b0, 1'b0);
    end else begin
      push_hw(16'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic clear_ring();
    hw_q.delete();
    gen_q.delete();
    for (int i = 0; i < N; i++) env_vld[i] = 1'b0;
    m_ptr  = 0;
    wr_ptr = 0;
  endtask

  // Write 0..4 half-words into the ring, as far as free entries allow.
  task automatic write_entries();
    int  k;
    hw_t h;
    k = $urandom_range(0, 4);
    for (int i = 0; i < k; i++) begin
      if (hw_q.size() >= N) break;
      if (gen_q.size() == 0) gen_inst();
      h = gen_q.pop_front();
      env_vld[wr_ptr]   = 1'b1;
      env_data[wr_ptr]  = h.data;
      env_start[wr_ptr] = h.start;
      env_acc[wr_ptr]   = h.acc;
      env_pc[wr_ptr]    = h.pc;
      hw_q.push_back(h);
      wr_ptr = (wr_ptr + 1) % N;
    end
  endtask

  // Evaluate one cycle of the reference model with the inputs now applied.
  task automatic model_step();
    exp_t         e;
    logic [N-1:0] ret;
    int           n;
    hw_t          dummy;
    e   = m_out;
    ret = '0;
    n   = 0;
    if (ibuf_flush) begin
      e.vld0 = 1'b0;
      e.vld1 = 1'b0;
      clear_ring();
    end else if (!m_out.vld0 || !idu_ifu_ib_stall) begin
      e.vld0 = 1'b0;
      e.vld1 = 1'b0;
      e.expt = 1'b0;
      if (hw_q.size() >= 1) begin
        if (hw_q[0].acc) begin
          e.vld0 = 1'b1; e.expt = 1'b1; e.b32_0 = 1'b0;
          e.d0 = {16'h0000, hw_q[0].data}; e.pc0 = hw_q[0].pc; n = 1;
        end else if (hw_q[0].start) begin
          if (hw_q.size() >= 2) begin
            e.vld0 = 1'b1; e.b32_0 = 1'b1;
            e.d0 = {hw_q[1].data, hw_q[0].data}; e.pc0 = hw_q[0].pc; n = 2;
          end
        end else begin
          e.vld0 = 1'b1; e.b32_0 = 1'b0;
          e.d0 = {16'h0000, hw_q[0].data}; e.pc0 = hw_q[0].pc; n = 1;
        end
      end
      if (e.vld0 && !e.expt && hw_q.size() > n && !hw_q[n].acc) begin
        if (hw_q[n].start) begin
          if (hw_q.size() > n + 1) begin
            e.vld1 = 1'b1; e.b32_1 = 1'b1;
            e.d1 = {hw_q[n+1].data, hw_q[n].data}; e.pc1 = hw_q[n].pc; n = n + 2;
          end
        end else begin
          e.vld1 = 1'b1; e.b32_1 = 1'b0;
          e.d1 = {16'h0000, hw_q[n].data}; e.pc1 = hw_q[n].pc; n = n + 1;
        end
      end
      for (int k = 0; k < n; k++) begin
        ret[(m_ptr + k) % N] = 1'b1;
        env_vld[(m_ptr + k) % N] = 1'b0;
        dummy = hw_q.pop_front();
      end
      m_ptr = (m_ptr + n) % N;
    end
    check("retire_v", 32'(entry_retire_v), 32'(ret));
    e.ptr = 4'(m_ptr);
    m_out = e;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_ptr"},     32'(rd_ptr),         32'd0);
    check({tag, "_inst0_vld"},  32'(inst0_vld),      32'd0);
    check({tag, "_inst1_vld"},  32'(inst1_vld),      32'd0);
    check({tag, "_inst0_data"}, inst0_data,          32'd0);
    check({tag, "_inst1_data"}, inst1_data,          32'd0);
    check({tag, "_inst0_pc"},   32'(inst0_pc),       32'd0);
    check({tag, "_inst1_pc"},   32'(inst1_pc),       32'd0);
    check({tag, "_inst0_32"},   32'(inst0_32),       32'd0);
    check({tag, "_inst1_32"},   32'(inst1_32),       32'd0);
    check({tag, "_inst0_expt"}, 32'(inst0_expt),     32'd0);
    check({tag, "_retire_v"},   32'(entry_retire_v), 32'd0);
  endtask

  task automatic model_reset();
    clear_ring();
    m_out      = '{default: '0};
    ibuf_flush = 1'b0;
    idu_ifu_ib_stall = 1'b0;
  endtask

  // Monitor: compare the output stage after every edge with the scoreboard.
  always @(posedge forever_cpuclk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("inst0_vld", 32'(inst0_vld), 32'(mon_e.vld0));
      check("inst1_vld", 32'(inst1_vld), 32'(mon_e.vld1));
      check("rd_ptr",    32'(rd_ptr),    32'(mon_e.ptr));
      if (mon_e.vld0) begin
        check("inst0_data", inst0_data,        mon_e.d0);
        check("inst0_32",   32'(inst0_32),   32'(mon_e.b32_0));
        check("inst0_pc",   32'(inst0_pc),   32'(mon_e.pc0));
        check("inst0_expt", 32'(inst0_expt), 32'(mon_e.expt));
      end
      if (mon_e.vld1) begin
        check("inst1_data", inst1_data,      mon_e.d1);
        check("inst1_32",   32'(inst1_32), 32'(mon_e.b32_1));
        check("inst1_pc",   32'(inst1_pc), 32'(mon_e.pc1));
      end
    end
  end

  task automatic seed_directed();
    push_hw(16'h1111, 1'b0, 1'b0);
    push_hw(16'h2222, 1'b0, 1'b0);
    push_hw(16'h3333, 1'b0, 1'b0);
    push_hw(16'h4444, 1'b0, 1'b0);
    push_hw(16'h1234, 1'b1, 1'b0);
    push_hw(16'hABCD, 1'b0, 1'b0);
    push_hw(16'h4501, 1'b0, 1'b0);
    push_hw(16'h5555, 1'b0, 1'b0);
    push_hw(16'h6666, 1'b0, 1'b1);
  endtask

  initial begin
    pc_ctr = 15'h0100;
    for (int i = 0; i < N; i++) begin
      env_vld[i]   = 1'b0;
      env_data[i]  = 16'($urandom);
      env_start[i] = 1'($urandom_range(0, 1));
      env_acc[i]   = 1'($urandom_range(0, 1));
      env_pc[i]    = 15'($urandom);
    end
    model_reset();
    drive_entries();
    cpurst_b = 1'b1;
    #2 cpurst_b = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    seed_directed();

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(negedge forever_cpuclk);
      if (cyc == CYCLES / 2) begin
        // Asynchronous reset in the middle of traffic.
        cpurst_b = 1'b0;
        model_reset();
        drive_entries();
        #1 check_reset_outputs("midreset");
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        seed_directed();
      end else begin
        idu_ifu_ib_stall = (cyc > 8) && ($urandom_range(0, 9) < 4);
        ibuf_flush       = (cyc > 8) && ($urandom_range(0, 59) == 0);
        drive_entries();
        #1;
        model_step();
        write_entries();
      end
    end

    @(negedge forever_cpuclk);
    ibuf_flush = 1'b0;
    idu_ifu_ib_stall = 1'b0;
    @(posedge forever_cpuclk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
